// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/busy inputs towards the controller and the
// per-stage write-enable / flush / fetch-kill controls coming back out of it.
interface pipeline_ctrl_if;
    logic load_use_haz;
    logic control_haz;
    logic imem_busy;
    logic dmem_busy;
    logic pc_we;
    logic if_de_we;
    logic if_de_flush;
    logic de_ex_we;
    logic de_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
    logic mem_wb_flush;
    logic fetch_kill;

    // Pipeline side: reports hazards and memory status, obeys the controls.
    modport master (
        output load_use_haz, control_haz, imem_busy, dmem_busy,
        input  pc_we, if_de_we, if_de_flush, de_ex_we, de_ex_flush,
               ex_mem_we, mem_wb_we, mem_wb_flush, fetch_kill
    );

    // Controller side.
    modport slave (
        input  load_use_haz, control_haz, imem_busy, dmem_busy,
        output pc_we, if_de_we, if_de_flush, de_ex_we, de_ex_flush,
               ex_mem_we, mem_wb_we, mem_wb_flush, fetch_kill
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: resolves hazards and memory waits into
// per-stage enables and NOP loads, tracks killed in-flight fetches (IKILL),
// counts stall/flush cycles and flags a hung memory handshake.
module pipeline_ctrl #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    pipeline_ctrl_if.slave bus,
    output logic          ikill,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt,
    output logic          timeout_err
);
    typedef enum logic {RUN = 1'b0, IKILL = 1'b1} state_t;

    localparam logic [15:0] BUSY_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [15:0] busy_cnt_reg, busy_cnt_next;
    logic        timeout_err_reg;

    logic ctl_pc_we, ctl_if_de_we, ctl_if_de_flush, ctl_de_ex_we, ctl_de_ex_flush;
    logic ctl_ex_mem_we, ctl_mem_wb_we, ctl_mem_wb_flush, ctl_fetch_kill;
    logic redirect_fire;
    logic mem_busy;

    assign mem_busy = bus.imem_busy | bus.dmem_busy;

    // State register; IKILL means a fetch issued before a redirect is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    // Priority resolution of controls and next state (dmem wait > redirect > load-use > fetch wait).
    always_comb begin
        ctl_pc_we        = 1'b1;
        ctl_if_de_we     = 1'b1;
        ctl_if_de_flush  = 1'b0;
        ctl_de_ex_we     = 1'b1;
        ctl_de_ex_flush  = 1'b0;
        ctl_ex_mem_we    = 1'b1;
        ctl_mem_wb_we    = 1'b1;
        ctl_mem_wb_flush = 1'b0;
        ctl_fetch_kill   = 1'b0;
        redirect_fire    = 1'b0;
        state_next       = state_reg;

        if (bus.dmem_busy) begin
            // Everything upstream of MEM freezes; a bubble drains into WB.
            // IKILL is held here even if the killed fetch returns now.
            ctl_pc_we        = 1'b0;
            ctl_if_de_we     = 1'b0;
            ctl_de_ex_we     = 1'b0;
            ctl_ex_mem_we    = 1'b0;
            ctl_mem_wb_flush = 1'b1;
        end else if (bus.control_haz) begin
            redirect_fire   = 1'b1;
            ctl_if_de_flush = 1'b1;
            ctl_de_ex_flush = 1'b1;
            if (bus.imem_busy || state_reg == IKILL) begin
                ctl_fetch_kill = 1'b1;
                state_next     = IKILL;
            end else begin
                state_next     = RUN;
            end
        end else begin
            if (bus.load_use_haz) begin
                ctl_pc_we       = 1'b0;
                ctl_if_de_we    = 1'b0;
                ctl_de_ex_flush = 1'b1;
            end else if (bus.imem_busy || state_reg == IKILL) begin
                // Hold the PC and keep IF/DE empty until a usable fetch lands.
                ctl_pc_we       = 1'b0;
                ctl_if_de_flush = 1'b1;
            end
            // The killed fetch retires on the first non-busy cycle.
            if (state_reg == IKILL && !bus.imem_busy) state_next = RUN;
        end
    end

    // Controls are forced inactive while reset is asserted.
    assign bus.pc_we        = rst_n & ctl_pc_we;
    assign bus.if_de_we     = rst_n & ctl_if_de_we;
    assign bus.if_de_flush  = rst_n & ctl_if_de_flush;
    assign bus.de_ex_we     = rst_n & ctl_de_ex_we;
    assign bus.de_ex_flush  = rst_n & ctl_de_ex_flush;
    assign bus.ex_mem_we    = rst_n & ctl_ex_mem_we;
    assign bus.mem_wb_we    = rst_n & ctl_mem_wb_we;
    assign bus.mem_wb_flush = rst_n & ctl_mem_wb_flush;
    assign bus.fetch_kill   = rst_n & ctl_fetch_kill;
    assign ikill            = (state_reg == IKILL);

    // Consecutive-busy counter, saturating at the timeout threshold.
    always_comb begin
        busy_cnt_next = busy_cnt_reg;
        if (!mem_busy)                      busy_cnt_next = '0;
        else if (busy_cnt_reg != BUSY_LAST) busy_cnt_next = busy_cnt_reg + 16'd1;
    end

    // Watchdog registers; the error is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            busy_cnt_reg <= busy_cnt_next;
            if (mem_busy && busy_cnt_reg == BUSY_LAST) timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;

    // Saturating performance counters: [0] stall cycles, [1] redirect flushes.
    logic [1:0]    cnt_inc;
    logic [CW-1:0] cnt_reg [2];

    assign cnt_inc[0] = ~ctl_pc_we;
    assign cnt_inc[1] = redirect_fire;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            // Count up on the event, stick at all ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi] && cnt_reg[gi] != {CW{1'b1}})
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the stimulus process computes expected
// outputs from a behavioural model and queues them; a monitor pops and checks
// each one at the falling edge of the same cycle.
module tb_pipeline_ctrl;
    localparam int CW      = 2;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct packed {
        logic          pc_we;
        logic          if_de_we;
        logic          if_de_flush;
        logic          de_ex_we;
        logic          de_ex_flush;
        logic          ex_mem_we;
        logic          mem_wb_we;
        logic          mem_wb_flush;
        logic          fetch_kill;
        logic          ikill;
        logic          timeout_err;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ikill;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic          timeout_err;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ikill       (ikill),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    obs_t exp_q [$];
    int   tag_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_steps  = 0;
    bit   done     = 1'b0;

    // Behavioural model state (touched only by the stimulus process).
    bit m_kill;       // a fetch abandoned by a redirect has not yet come back
    int m_busy_run;   // consecutive cycles with any memory busy
    int m_stall;
    int m_flush;
    bit m_terr;

    task automatic model_reset();
        m_kill = 0; m_busy_run = 0; m_stall = 0; m_flush = 0; m_terr = 0;
    endtask

    // One cycle: apply inputs, queue expected observation, advance model over the edge.
    task automatic step(input bit r, input bit lu, input bit ch, input bit ib, input bit db);
        obs_t e;
        @(posedge clk);
        #1;
        rst_n            = r;
        bus.load_use_haz = lu;
        bus.control_haz  = ch;
        bus.imem_busy    = ib;
        bus.dmem_busy    = db;
        e = '0;
        if (!r) begin
            model_reset();
        end else begin
            e.ikill       = m_kill;
            e.timeout_err = m_terr;
            e.stall_cnt   = CW'(m_stall);
            e.flush_cnt   = CW'(m_flush);
            if (db) begin
                e.mem_wb_we = 1; e.mem_wb_flush = 1;
            end else if (ch) begin
                e.pc_we = 1; e.if_de_we = 1; e.de_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
                e.if_de_flush = 1; e.de_ex_flush = 1;
                e.fetch_kill = ib | m_kill;
            end else if (lu) begin
                e.de_ex_we = 1; e.de_ex_flush = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
            end else if (ib || m_kill) begin
                e.if_de_we = 1; e.if_de_flush = 1; e.de_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
            end else begin
                e.pc_we = 1; e.if_de_we = 1; e.de_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
            end
            // Edge update.
            if (ib || db) begin
                m_busy_run++;
                if (m_busy_run >= TIMEOUT) m_terr = 1;
            end else begin
                m_busy_run = 0;
            end
            if (!e.pc_we && m_stall < CMAX) m_stall++;
            if (ch && !db && m_flush < CMAX) m_flush++;
            if (!db) begin
                if (ch)          m_kill = ib | m_kill;
                else if (m_kill) m_kill = ib;
            end
        end
        exp_q.push_back(e);
        tag_q.push_back(n_steps);
        n_steps++;
    endtask

    // Monitor: check the queued expectation against the DUT mid-cycle.
    initial begin
        obs_t e, a;
        int   t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a.pc_we        = bus.pc_we;
                a.if_de_we     = bus.if_de_we;
                a.if_de_flush  = bus.if_de_flush;
                a.de_ex_we     = bus.de_ex_we;
                a.de_ex_flush  = bus.de_ex_flush;
                a.ex_mem_we    = bus.ex_mem_we;
                a.mem_wb_we    = bus.mem_wb_we;
                a.mem_wb_flush = bus.mem_wb_flush;
                a.fetch_kill   = bus.fetch_kill;
                a.ikill        = ikill;
                a.timeout_err  = timeout_err;
                a.stall_cnt    = stall_cnt;
                a.flush_cnt    = flush_cnt;
                n_checks++;
                if (a === e) begin
                    n_pass++;
                    $display("txn %0d rst_n=%b lu=%b ch=%b ib=%b db=%b obs=%h ok", t, rst_n,
                             bus.load_use_haz, bus.control_haz, bus.imem_busy, bus.dmem_busy, a);
                end else begin
                    $display("FAIL txn_%0d ctrl_obs: actual=%h expected=%h (pc,ifw,iff,dew,def,emw,mww,mwf,fk,ikill,terr,stall,flush)",
                             t, a, e);
                end
            end
            if (done && exp_q.size() == 0) break;
        end
        n_checks++;
        if (tag_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: actual=%0d left required=0", tag_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL sim_timeout: actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    // Stimulus.
    initial begin
        bus.load_use_haz = 0; bus.control_haz = 0; bus.imem_busy = 0; bus.dmem_busy = 0;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);                       // idle after reset
        // Load-use bubble then normal flow.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Redirect with fetch in flight, killed fetch outstanding 3 more cycles.
        step(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Redirect while MEM is waiting: only the WB bubble until dmem frees.
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        // Reset mid-operation with dmem busy, then release idle.
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Watchdog: four busy cycles, then idle; error stays set.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        // Three busy cycles must not trip it after a reset.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // Stall saturation.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // IKILL exit blocked by dmem wait, then redirect while still in IKILL.
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        step(1, 0, 0, 0, 0);
        @(posedge clk);
        done = 1'b1;
    end
endmodule
